// File: rtl/voter_pkg.sv
// Shared types and constants for the voting-session block.
package voter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OPEN   = 2'd1,
      COUNT  = 2'd2,
      RESULT = 2'd3
   } state_t;

   localparam logic [1:0] RES_NOQ  = 2'b00;
   localparam logic [1:0] RES_PASS = 2'b01;
   localparam logic [1:0] RES_FAIL = 2'b10;
   localparam logic [1:0] RES_TIE  = 2'b11;

   localparam int MODE_MAJ   = 0;
   localparam int MODE_SUPER = 1;

endpackage

// File: rtl/voter_popcount.sv
// Combinational ones-count of a W-bit vector.
module voter_popcount #(
   parameter  int W  = 4,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  bits,
   output logic [CW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(bits[i]);
      end
   end

endmodule

// File: rtl/voter_tally.sv
// Timed voting sessions: collects one ballot per voter, tallies at close and
// holds a quorum/majority verdict until acknowledged.
module voter_tally
   import voter_pkg::*;
#(
   parameter  int N_VOTERS   = 4,
   parameter  int WINDOW_CYC = 16,
   parameter  int QUORUM     = 3,
   parameter  int MODE       = 0,
   localparam int CNT_W      = $clog2(N_VOTERS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [N_VOTERS-1:0] vote_valid,
   input  logic [N_VOTERS-1:0] vote_yes,
   input  logic                close,
   input  logic                res_ack,
   output logic                busy,
   output logic [N_VOTERS-1:0] voted,
   output logic [CNT_W-1:0]    yes_cnt,
   output logic [CNT_W-1:0]    no_cnt,
   output logic                res_valid,
   output logic [1:0]          res_code
);

   localparam int TMR_W = $clog2(WINDOW_CYC + 1);
   localparam int CMP_W = CNT_W + 2;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    timer_q;
   logic [N_VOTERS-1:0] voted_q, ballot_q;
   logic [CNT_W-1:0]    yes_cnt_q, no_cnt_q;
   logic [1:0]          res_code_q;

   logic [N_VOTERS-1:0] accept, voted_open, ballot_open;
   logic                all_voted;
   logic [CNT_W-1:0]    yes_pop, no_pop;

   // Widened so 3*yes and 2*total cannot wrap for any legal N_VOTERS.
   function automatic logic [1:0] verdict(input logic [CNT_W-1:0] y,
                                          input logic [CNT_W-1:0] n);
      logic [CMP_W-1:0] yw, nw, tw, y3, t2;
      yw = CMP_W'(y);
      nw = CMP_W'(n);
      tw = yw + nw;
      y3 = yw + (yw << 1);
      t2 = tw << 1;
      if (tw < CMP_W'(QUORUM))   return RES_NOQ;
      else if (MODE == MODE_SUPER) return (y3 >= t2) ? RES_PASS : RES_FAIL;
      else if (yw > nw)          return RES_PASS;
      else if (nw > yw)          return RES_FAIL;
      else                       return RES_TIE;
   endfunction

   // First strobe per voter wins; later strobes from the same voter are masked.
   assign accept      = vote_valid & ~voted_q;
   assign voted_open  = voted_q | accept;
   assign ballot_open = (ballot_q & ~accept) | (vote_yes & accept);
   assign all_voted   = &voted_open;

   voter_popcount #(.W(N_VOTERS)) u_pop_yes (
      .bits  (voted_q & ballot_q),
      .count (yes_pop)
   );

   voter_popcount #(.W(N_VOTERS)) u_pop_no (
      .bits  (voted_q & ~ballot_q),
      .count (no_pop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = OPEN;
         OPEN:    if ((timer_q == '0) || close || all_voted) state_d = COUNT;
         COUNT:   state_d = RESULT;
         RESULT:  if (res_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q    <= '0;
         voted_q    <= '0;
         ballot_q   <= '0;
         yes_cnt_q  <= '0;
         no_cnt_q   <= '0;
         res_code_q <= RES_NOQ;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  timer_q    <= TMR_W'(WINDOW_CYC - 1);
                  voted_q    <= '0;
                  ballot_q   <= '0;
                  yes_cnt_q  <= '0;
                  no_cnt_q   <= '0;
                  res_code_q <= RES_NOQ;
               end
            end
            OPEN: begin
               voted_q  <= voted_open;
               ballot_q <= ballot_open;
               if (timer_q != '0) timer_q <= timer_q - TMR_W'(1);
            end
            COUNT: begin
               yes_cnt_q  <= yes_pop;
               no_cnt_q   <= no_pop;
               res_code_q <= verdict(yes_pop, no_pop);
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == RESULT);
   assign voted     = voted_q;
   assign yes_cnt   = yes_cnt_q;
   assign no_cnt    = no_cnt_q;
   assign res_code  = res_code_q;

endmodule
